// File: rtl/io_mem_pkg.sv
// io_mem_pkg: shared encodings for the burst responder slice.
// Holds FSM states, write response codes and the byte-to-word offset.
package io_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      WRESP = 2'd3
   } state_t;

   localparam logic RESP_OK  = 1'b1;
   localparam logic RESP_ERR = 1'b0;

   localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/mem_rd_skid.sv
// mem_rd_skid: 2-entry valid/ready buffer for SRAM read data.
// Ports: in_valid/in_data (SRAM side), out_* (initiator side), occupancy.
module mem_rd_skid
   import io_mem_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic [DWIDTH-1:0] slot_q [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;
   logic              held;
   logic              pop;
   logic              store;
   logic              drain;

   // When empty, incoming data bypasses the slots so a beat
   // is visible in the same cycle the SRAM returns it.
   assign held      = count_q != 2'd0;
   assign out_valid = held | in_valid;
   assign out_data  = held     ? slot_q[rd_ptr_q] :
                      in_valid ? in_data : '0;
   assign pop       = out_valid & out_ready;
   assign store     = in_valid & (held | ~pop);
   assign drain     = pop & held;
   assign occupancy = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (store) wr_ptr_q <= ~wr_ptr_q;
         if (drain) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, store} - {1'b0, drain};
      end
   end

   always_ff @(posedge clk) begin
      if (store) slot_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: rtl/io_mem_burst_responder.sv
// io_mem_burst_responder: serves read/write bursts against a 1-cycle SRAM.
// Ports: req_read_*/rdata*, req_write_*/resp_write_*, mem_* SRAM port.
// Option MEM_BOUNDS_CHECK_EN: out-of-range beats read 0 / write error.
module io_mem_burst_responder
   import io_mem_pkg::*;
#(
   parameter int AWIDTH       = 32,
   parameter int DWIDTH       = 32,
   parameter int MEM_LOGDEPTH = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AWIDTH-1:0]       req_read_addr,
   input  logic                    req_read_addr_valid,
   output logic                    req_read_addr_ready,
   input  logic [31:0]             req_read_len,
   output logic [DWIDTH-1:0]       rdata,
   output logic                    rdata_valid,
   input  logic                    rdata_ready,
   input  logic [AWIDTH-1:0]       req_write_addr,
   input  logic                    req_write_addr_valid,
   output logic                    req_write_addr_ready,
   input  logic [31:0]             req_write_len,
   input  logic [DWIDTH-1:0]       req_write_data,
   input  logic                    req_write_data_valid,
   output logic                    req_write_data_ready,
   output logic                    resp_write_status,
   output logic                    resp_write_status_valid,
   input  logic                    resp_write_status_ready,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [MEM_LOGDEPTH-1:0] mem_addr,
   output logic [DWIDTH-1:0]       mem_wdata,
   input  logic [DWIDTH-1:0]       mem_rdata
);

   localparam int WA = AWIDTH - WORD_OFFSET;
   localparam logic [WA-1:0] WSTEP = WA'(1);

   state_t            state_q;
   state_t            state_d;
   logic              prio_wr_q;
   logic [WA-1:0]     addr_q;
   logic [31:0]       len_q;
   logic [31:0]       issued_q;
   logic [31:0]       beat_q;
   logic              inflight_q;
   logic              inflight_oob_q;
   logic              err_q;
   logic              idle;
   logic              oob;
   logic              rd_issue;
   logic              rd_addr_fire;
   logic              wr_addr_fire;
   logic              rd_beat_fire;
   logic              wr_beat_fire;
   logic [1:0]        occ;
   logic [DWIDTH-1:0] skid_in;
   logic              unused_bits;

   // Readys are gated by reset so nothing is accepted while held.
   // On a tie only the side holding priority sees ready.
   assign idle = rst & (state_q == IDLE);
   assign req_read_addr_ready =
      idle & ~(req_write_addr_valid & prio_wr_q);
   assign req_write_addr_ready =
      idle & ~(req_read_addr_valid & ~prio_wr_q);
   assign rd_addr_fire = req_read_addr_valid & req_read_addr_ready;
   assign wr_addr_fire = req_write_addr_valid & req_write_addr_ready;

   assign req_write_data_ready = state_q == WRITE;
   assign wr_beat_fire = req_write_data_valid & req_write_data_ready;
   assign rd_beat_fire = rdata_valid & rdata_ready;

   assign mem_addr = addr_q[MEM_LOGDEPTH-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = |(addr_q >> MEM_LOGDEPTH);
`else
   assign oob = 1'b0;
`endif

   assign unused_bits = ^{req_read_addr, req_write_addr, addr_q};

   assign skid_in = inflight_oob_q ? '0 : mem_rdata;

   mem_rd_skid #(
      .DWIDTH(DWIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight_q),
      .in_data   (skid_in),
      .out_valid (rdata_valid),
      .out_ready (rdata_ready),
      .out_data  (rdata),
      .occupancy (occ)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d                 = state_q;
      rd_issue                = 1'b0;
      mem_en                  = 1'b0;
      mem_we                  = 1'b0;
      mem_wdata               = '0;
      resp_write_status_valid = 1'b0;
      resp_write_status       = RESP_ERR;
      unique case (state_q)
         IDLE: begin
            if (rd_addr_fire) begin
               if (req_read_len != 32'd0) state_d = READ;
            end else if (wr_addr_fire) begin
               state_d = (req_write_len != 32'd0) ? WRITE : WRESP;
            end
         end
         READ: begin
            // Credit: stored beats plus the one in flight never exceed 2.
            rd_issue = (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2)
                       && (issued_q < len_q);
            mem_en = rd_issue & ~oob;
            if (rd_beat_fire && (beat_q + 32'd1 == len_q))
               state_d = IDLE;
         end
         WRITE: begin
            if (wr_beat_fire) begin
               mem_en    = ~oob;
               mem_we    = ~oob;
               mem_wdata = req_write_data;
               if (beat_q + 32'd1 == len_q) state_d = WRESP;
            end
         end
         WRESP: begin
            resp_write_status_valid = 1'b1;
            resp_write_status       = err_q ? RESP_ERR : RESP_OK;
            if (resp_write_status_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_wr_q      <= 1'b1;
         addr_q         <= '0;
         len_q          <= '0;
         issued_q       <= '0;
         beat_q         <= '0;
         inflight_q     <= 1'b0;
         inflight_oob_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         inflight_q     <= rd_issue;
         inflight_oob_q <= rd_issue & oob;
         if (rd_addr_fire | wr_addr_fire) begin
            prio_wr_q <= ~prio_wr_q;
            addr_q    <= rd_addr_fire ?
                         req_read_addr[AWIDTH-1:WORD_OFFSET] :
                         req_write_addr[AWIDTH-1:WORD_OFFSET];
            len_q     <= rd_addr_fire ? req_read_len : req_write_len;
            issued_q  <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
         end
         if (rd_issue) begin
            issued_q <= issued_q + 32'd1;
            addr_q   <= addr_q + WSTEP;
         end
         if (rd_beat_fire) beat_q <= beat_q + 32'd1;
         if (wr_beat_fire) begin
            beat_q <= beat_q + 32'd1;
            addr_q <= addr_q + WSTEP;
            if (oob) err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_io_mem_burst_responder.sv
// tb_io_mem_burst_responder: directed + random bursts for the responder.
// SRAM is modelled here; expected data comes from a word-array reference.
module tb_io_mem_burst_responder;

   localparam int MLD   = 14;
   localparam int DEPTH = 1 << MLD;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [31:0]     req_read_addr = '0;
   logic            req_read_addr_valid = 1'b0;
   logic            req_read_addr_ready;
   logic [31:0]     req_read_len = '0;
   logic [31:0]     rdata;
   logic            rdata_valid;
   logic            rdata_ready = 1'b0;
   logic [31:0]     req_write_addr = '0;
   logic            req_write_addr_valid = 1'b0;
   logic            req_write_addr_ready;
   logic [31:0]     req_write_len = '0;
   logic [31:0]     req_write_data = '0;
   logic            req_write_data_valid = 1'b0;
   logic            req_write_data_ready;
   logic            resp_write_status;
   logic            resp_write_status_valid;
   logic            resp_write_status_ready = 1'b0;
   logic            mem_en;
   logic            mem_we;
   logic [MLD-1:0]  mem_addr;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;

   logic            bd_en = 1'b0;
   logic [MLD-1:0]  bd_addr = '0;
   logic [31:0]     bd_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_mem_burst_responder #(
      .AWIDTH(32), .DWIDTH(32), .MEM_LOGDEPTH(MLD)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .req_read_addr           (req_read_addr),
      .req_read_addr_valid     (req_read_addr_valid),
      .req_read_addr_ready     (req_read_addr_ready),
      .req_read_len            (req_read_len),
      .rdata                   (rdata),
      .rdata_valid             (rdata_valid),
      .rdata_ready             (rdata_ready),
      .req_write_addr          (req_write_addr),
      .req_write_addr_valid    (req_write_addr_valid),
      .req_write_addr_ready    (req_write_addr_ready),
      .req_write_len           (req_write_len),
      .req_write_data          (req_write_data),
      .req_write_data_valid    (req_write_data_valid),
      .req_write_data_ready    (req_write_data_ready),
      .resp_write_status       (resp_write_status),
      .resp_write_status_valid (resp_write_status_valid),
      .resp_write_status_ready (resp_write_status_ready),
      .mem_en                  (mem_en),
      .mem_we                  (mem_we),
      .mem_addr                (mem_addr),
      .mem_wdata               (mem_wdata),
      .mem_rdata               (mem_rdata)
   );

   // Untouched words read back a fixed hash of their index.
   function automatic logic [31:0] init_val(input int w);
      logic [31:0] x;
      x = 32'(w);
      return (x * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   // SRAM model: synchronous single port, 1-cycle read latency.
   logic [31:0] sram [DEPTH];
   bit          sram_wr [DEPTH];
   always @(posedge clk) begin
      if (bd_en) begin
         sram[bd_addr]    <= bd_data;
         sram_wr[bd_addr] <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) begin
            sram[mem_addr]    <= mem_wdata;
            sram_wr[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr]
                                           : init_val(int'(mem_addr));
         end
      end
   end

   // Reference memory: what every word should hold.
   logic [31:0] ref_mem [DEPTH];
   bit          ref_wr [DEPTH];

   function automatic logic [31:0] ref_rd(input int w);
      return ref_wr[w] ? ref_mem[w] : init_val(w);
   endfunction

   task automatic ref_put(input int w, input logic [31:0] d);
      ref_mem[w] = d;
      ref_wr[w]  = 1'b1;
   endtask

   function automatic int word_of(input logic [31:0] ba, input int i);
      logic [31:0] t;
      t = (ba >> 2) + 32'(i);
      return int'(t[MLD-1:0]);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int w, input logic [31:0] d);
      bd_en   = 1'b1;
      bd_addr = MLD'(w);
      bd_data = d;
      @(posedge clk); #1;
      bd_en = 1'b0;
      ref_put(w, d);
   endtask

   task automatic rd_addr_phase(input logic [31:0] ba, input int len);
      int cyc;
      cyc = 0;
      req_read_addr = ba;
      req_read_len = 32'(len);
      req_read_addr_valid = 1'b1;
      @(negedge clk);
      while (!req_read_addr_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("rd_addr_accept", 64'(req_read_addr_ready), 64'd1);
      @(posedge clk); #1;
      req_read_addr_valid = 1'b0;
      req_read_addr = $urandom;
      req_read_len = $urandom;
   endtask

   task automatic wr_addr_phase(input logic [31:0] ba, input int len);
      int cyc;
      cyc = 0;
      req_write_addr = ba;
      req_write_len = 32'(len);
      req_write_addr_valid = 1'b1;
      @(negedge clk);
      while (!req_write_addr_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("wr_addr_accept", 64'(req_write_addr_ready), 64'd1);
      @(posedge clk); #1;
      req_write_addr_valid = 1'b0;
      req_write_addr = $urandom;
      req_write_len = $urandom;
   endtask

   // mode 0: always ready (also checks T+2 latency, no bubbles)
   // mode 1: ready pattern 1,0,0; mode 2: random ready.
   // abort>0: async reset right after that many beats.
   task automatic do_read(input logic [31:0] ba, input int len,
                          input int mode, input int abort);
      int got;
      int cyc;
      bit stall;
      logic [31:0] held;
      got = 0;
      cyc = 1;
      stall = 1'b0;
      held = '0;
      rd_addr_phase(ba, len);
      while (got < len && cyc < 8 * len + 20) begin
         if (mode == 0) rdata_ready = 1'b1;
         else if (mode == 1) rdata_ready = ((cyc - 1) % 3 == 0);
         else rdata_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (stall)
            check("rd_stall_hold", {31'd0, rdata_valid, rdata},
                  {31'd0, 1'b1, held});
         stall = 1'b0;
         if (rdata_valid) begin
            if (rdata_ready) begin
               check("rd_data", 64'(rdata), 64'(ref_rd(word_of(ba, got))));
               if (mode == 0)
                  check("rd_timing", 64'(cyc), 64'(got + 2));
               got++;
            end else begin
               stall = 1'b1;
               held = rdata;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (abort != 0 && got == abort) begin
            #2 rst = 1'b0;
            #1;
            check("rst_outputs",
                  {24'd0, rdata_valid, rdata, mem_en, mem_we,
                   req_read_addr_ready, req_write_addr_ready,
                   req_write_data_ready, resp_write_status_valid,
                   resp_write_status}, 64'd0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            rdata_ready = 1'b0;
            return;
         end
      end
      check("rd_beats", 64'(got), 64'(len));
      rdata_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rd_idle", {62'd0, req_read_addr_ready, rdata_valid},
               64'd2);
         @(posedge clk); #1;
      end
      rdata_ready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] ba, input int len,
                           input bit gaps, input logic [31:0] d0);
      int cyc;
      bit done;
      bit stall;
      logic held;
      wr_addr_phase(ba, len);
      for (int i = 0; i < len; i++) begin
         int g;
         int w;
         logic [31:0] d;
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         for (int k = 0; k < g; k++) begin
            req_write_data_valid = 1'b0;
            req_write_data = $urandom;
            @(negedge clk);
            check("wr_gap_idle", {62'd0, mem_en, mem_we}, 64'd0);
            @(posedge clk); #1;
         end
         d = (d0 != 0) ? d0 + 32'(i) : $urandom;
         w = word_of(ba, i);
         req_write_data = d;
         req_write_data_valid = 1'b1;
         cyc = 0;
         @(negedge clk);
         while (!req_write_data_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         check("wr_data_ready", 64'(req_write_data_ready), 64'd1);
         check("wr_mem_port", {16'd0, mem_en, mem_we, mem_addr, mem_wdata},
               {16'd0, 1'b1, 1'b1, MLD'(w), d});
         ref_put(w, d);
         @(posedge clk); #1;
         req_write_data_valid = 1'b0;
      end
      cyc = 0;
      done = 1'b0;
      stall = 1'b0;
      held = 1'b0;
      while (!done && cyc < 30) begin
         resp_write_status_ready =
            (cyc > 4) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (cyc == 0)
            check("wr_resp_lat", 64'(resp_write_status_valid), 64'd1);
         if (stall)
            check("wr_resp_hold",
                  {62'd0, resp_write_status_valid, resp_write_status},
                  {62'd0, 1'b1, held});
         stall = 1'b0;
         if (resp_write_status_valid) begin
            if (resp_write_status_ready) begin
               check("wr_status", 64'(resp_write_status), 64'd1);
               done = 1'b1;
            end else begin
               stall = 1'b1;
               held = resp_write_status;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("wr_resp_seen", 64'(done), 64'd1);
      @(negedge clk);
      check("wr_resp_once", 64'(resp_write_status_valid), 64'd0);
      @(posedge clk); #1;
      resp_write_status_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int w;
      logic [31:0] ba;

      // Reset: handshake inputs high must not open any ready.
      req_read_addr_valid = 1'b1;
      req_write_addr_valid = 1'b1;
      req_write_data_valid = 1'b1;
      rdata_ready = 1'b1;
      resp_write_status_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state",
            {24'd0, rdata_valid, rdata, mem_en, mem_we,
             req_read_addr_ready, req_write_addr_ready,
             req_write_data_ready, resp_write_status_valid,
             resp_write_status}, 64'd0);
      req_read_addr_valid = 1'b0;
      req_write_addr_valid = 1'b0;
      req_write_data_valid = 1'b0;
      rdata_ready = 1'b0;
      resp_write_status_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_readys",
            {62'd0, req_read_addr_ready, req_write_addr_ready}, 64'd3);
      @(posedge clk); #1;

      // Arbitration: write wins first tie, read wins the next.
      req_read_addr = 32'h80;
      req_read_len = 32'd3;
      req_write_addr = 32'h200;
      req_write_len = 32'd2;
      req_read_addr_valid = 1'b1;
      req_write_addr_valid = 1'b1;
      @(negedge clk);
      check("arb_first",
            {62'd0, req_read_addr_ready, req_write_addr_ready}, 64'd1);
      req_read_addr_valid = 1'b0;
      req_write_addr_valid = 1'b0;
      @(posedge clk); #1;
      do_write(32'h200, 2, 1'b0, 32'd0);
      req_read_addr_valid = 1'b1;
      req_write_addr_valid = 1'b1;
      @(negedge clk);
      check("arb_second",
            {62'd0, req_read_addr_ready, req_write_addr_ready}, 64'd2);
      req_read_addr_valid = 1'b0;
      req_write_addr_valid = 1'b0;
      @(posedge clk); #1;
      do_read(32'h80, 3, 0, 0);

      // Read bursts over preloaded words 0x10..0x18 = 1..9.
      for (int i = 0; i < 9; i++) preload(16 + i, 32'(i + 1));
      do_read(32'h40, 9, 0, 0);
      do_read(32'h40, 9, 1, 0);

      // Write burst with gaps, then read back.
      do_write(32'h100, 4, 1'b1, 32'hA);
      do_read(32'h100, 4, 0, 0);

      // Zero-length bursts.
      do_read(32'h40, 0, 0, 0);
      do_write(32'h300, 0, 1'b0, 32'd0);

      // Async reset mid-read, then a clean burst.
      do_read(32'h40, 9, 2, 3);
      do_read(32'h40, 9, 0, 0);

      // Wrap at the top of the SRAM and aliasing upper bits.
      do_write(32'((DEPTH - 2) << 2), 4, 1'b1, 32'h100);
      do_read(32'((DEPTH - 2) << 2), 4, 0, 0);
      do_read(32'hABC0_0043, 9, 2, 0);

      // Random bursts.
      for (int n = 0; n < 30; n++) begin
         len = int'($urandom_range(0, 12));
         if ($urandom_range(0, 3) == 0)
            w = DEPTH - 1 - int'($urandom_range(0, 5));
         else
            w = int'($urandom_range(0, 63));
         ba = ($urandom & 32'hFFFF_0000) | (32'(w) << 2)
              | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(ba, len, 1'($urandom_range(0, 1)), 32'd0);
         else
            do_read(ba, len, int'($urandom_range(0, 2)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/io_mem_burst_responder.md
Name: io_mem_burst_responder

Overview:
Memory-side responder for the accelerator burst request interface (read addr/data, write addr/data, write response). It accepts one burst at a time from a single initiator, such as a conv2D compute engine. It services each burst against a word-addressed synchronous single-port SRAM with 1-cycle read latency. Reads sustain 1 beat/cycle under rdata backpressure via a 2-entry skid buffer.

Parameters:
AWIDTH, 32, byte address width of request channels
DWIDTH, 32, data word width
MEM_LOGDEPTH, 14, log2 of SRAM depth in words

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
req_read_addr  in  AWIDTH  burst start byte address, word aligned
req_read_addr_valid  in  1  read address valid
req_read_addr_ready  out  1  read address accepted
req_read_len  in  32  read burst length in words
rdata  out  DWIDTH  read beat
rdata_valid  out  1  read beat valid
rdata_ready  in  1  initiator accepts beat
req_write_addr  in  AWIDTH  write burst start byte address
req_write_addr_valid  in  1  write address valid
req_write_addr_ready  out  1  write address accepted
req_write_len  in  32  write burst length in words
req_write_data  in  DWIDTH  write beat
req_write_data_valid  in  1  write beat valid
req_write_data_ready  out  1  write beat accepted
resp_write_status  out  1  1 = OK, 0 = error
resp_write_status_valid  out  1  response valid
resp_write_status_ready  in  1  response accepted
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  MEM_LOGDEPTH  SRAM word address
mem_wdata  out  DWIDTH  SRAM write data
mem_rdata  in  DWIDTH  SRAM read data, valid cycle after mem_en & ~mem_we

Behaviour:
- Reset (async assert, sync deassert by the integrator): state IDLE; all ready/valid outputs 0, mem_en=mem_we=0, rdata=0, resp_write_status=0; skid buffer emptied; the burst in progress is abandoned with no response.
- Fire = valid & ready on any channel. Word address = byte address[MEM_LOGDEPTH+1:2]; bits [1:0] are ignored. The word address increments by 1 per beat and wraps modulo 2^MEM_LOGDEPTH.
- States: IDLE, READ, WRITE, WRESP.
- IDLE: both addr readys are asserted combinationally. The arbiter allows only one to fire. If both valids are high, priority alternates via a 1-bit toggle: after reset, write wins; the toggle flips on every addr fire. The base address and len are latched, and the beat counter is cleared.
- IDLE->READ on read addr fire with len>0. len==0 stays in IDLE.
- IDLE->WRITE on write addr fire with len>0. len==0 goes to WRESP directly with status 1.
- READ: issue an SRAM read when (skid occupancy + in-flight) < 2 and issued < len. The data lands in the skid buffer the next cycle. rdata/rdata_valid come from the skid head.
- READ latency: addr fire at cycle T -> first mem_en at T+1 -> rdata_valid at T+2. With rdata_ready held high, 1 beat/cycle and no bubbles.
- READ->IDLE when all len beats have fired on rdata. The last beat's fire cycle is the final READ cycle.
- WRITE: req_write_data_ready=1. Each fire drives mem_en=mem_we=1, mem_wdata=req_write_data and the current address in the same cycle. No bubbles.
- WRITE->WRESP on the fire of beat len.
- WRESP: resp_write_status_valid=1 and is held with a stable status until the fire, then -> IDLE.
- Counters are 32-bit; len is taken unsigned; max len 2^32-1.
- The address, len and data inputs are ignored outside their accepting states.

Optional Feature:
MEM_BOUNDS_CHECK_EN
- Defined: any beat whose byte address exceeds the SRAM range (upper address bits nonzero, no wrap) is handled as an error.
  - Read beats return 0, and mem_en is suppressed for that beat.
  - Write beats are accepted but not written (mem_we=0); a sticky error flag makes resp_write_status=0.
- Undefined: address bits above the SRAM range are ignored, and all writes return status 1.

Decomposition:
- Shared package (io_mem_pkg): state encodings, response codes RESP_OK=1 / RESP_ERR=0, and the word-offset constant (2).
- One natural sub-module: mem_rd_skid, the 2-entry valid/ready buffer with an occupancy output, used by the READ path. It is kept separate from the general fifo for exact credit timing.

Test Plan:
- Read burst: preload words 0x10..0x18 = 1..9; read addr 0x40, len 9, rdata_ready=1 -> beats 1..9 on consecutive cycles, first at T+2, then IDLE.
- Read backpressure: same burst with rdata_ready toggling 1,0,0,1... -> no beat lost or duplicated, rdata stable while stalled, order 1..9.
- Write burst:
  - Stimulus: write addr 0x100, len 4, data 0xA,0xB,0xC,0xD with valid gaps, then read back.
  - Response: resp status 1 once after 4th beat; readback 0xA..0xD.
- Arbitration: read and write valid in same cycle after reset -> write granted first; next simultaneous request -> read granted.
- Zero length and reset:
  - len=0 read -> no rdata_valid; len=0 write -> immediate resp status 1.
  - Async reset mid-read at beat 3 -> outputs 0 immediately, IDLE, next burst correct.
- Bounds (MEM_BOUNDS_CHECK_EN, MEM_LOGDEPTH=4): write addr 0x3C, len 2 -> resp status 0; word 15 written, out-of-range beat dropped.
